n64_vdemux: RTL and testbench

- Video front-end stage that de-multiplexes the N64 7-bit video bus (one sync word plus R, G and B words per pixel) into a parallel, registered pixel word.
- Produces the Sync_pre/Sync_cur history vectors consumed by the video-info extractor.
- Uses the extractor's data_cnt (vinfo_i[3:2]) to place each bus word in the correct colour slot.
- Flags bus-sequence errors, and optionally truncates colour to 15-bit depth.

---
 rtl/n64_vdemux.sv | 110 +++++++++++
 tb/tb_n64_vdemux.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/n64_vdemux.sv
// n64_vdemux: de-multiplexes the N64 7-bit video bus (sync, R, G, B words)
// into one registered pixel word. It keeps a two-deep sync history for the
// video-info extractor and counts malformed bus sequences.
module n64_vdemux #(
  parameter int color_width   = 7,
  parameter int err_cnt_width = 8
) (
  input  logic                       VCLK,
  input  logic                       nRST,
  input  logic                       nDSYNC,
  input  logic [color_width-1:0]     D_i,
  input  logic [3:0]                 vinfo_i,
  input  logic                       n15bit_mode,
  output logic [3:0]                 Sync_pre,
  output logic [3:0]                 Sync_cur,
  output logic [3*color_width+3:0]   vdata_o,
  output logic                       vdata_valid_o,
  output logic                       seq_err_o,
  output logic [err_cnt_width-1:0]   err_cnt_o
);

  localparam logic [err_cnt_width-1:0] CNT_ONE = {{(err_cnt_width-1){1'b0}}, 1'b1};
  localparam logic [err_cnt_width-1:0] CNT_MAX = {err_cnt_width{1'b1}};

  // 15-bit colour keeps only the upper five bits of each channel.
  function automatic logic [color_width-1:0] depth_mask(
    input logic [color_width-1:0] v,
    input logic                   full_depth
  );
    logic [color_width-1:0] r;
    r = v;
    if (!full_depth) r[1:0] = 2'b00;
    return r;
  endfunction

  logic [color_width-1:0]   r_tmp;
  logic [color_width-1:0]   g_tmp;
  logic                     phase_ok;

  logic [1:0]               data_cnt;
  logic                     is_sync;
  logic                     vs_rise;
  logic                     capture;
  logic                     err_evt;
  logic [err_cnt_width-1:0] cnt_next;
  logic                     unused_vinfo;

  // The extractor's mode bits are not needed for the demultiplexing itself.
  assign unused_vinfo = ^vinfo_i[1:0];

  // Decode the current bus word and work out the next error-counter value.
  always_comb begin
    data_cnt = vinfo_i[3:2];
    is_sync  = !nDSYNC;
    // Rising edge of nVSYNC: previous sync had it low, this one has it high.
    vs_rise  = is_sync && !Sync_cur[3] && D_i[3];
    capture  = nDSYNC && (data_cnt == 2'b11) && phase_ok;
    if (is_sync)
      err_evt = (data_cnt != 2'b00);
    else
      err_evt = (data_cnt == 2'b00) || ((data_cnt == 2'b11) && !phase_ok);

    // A frame start clears the count; an error on that same cycle counts as the first.
    cnt_next = err_cnt_o;
    if (vs_rise)
      cnt_next = err_evt ? CNT_ONE : '0;
    else if (err_evt && (err_cnt_o != CNT_MAX))
      cnt_next = err_cnt_o + CNT_ONE;
  end

  // Sync history, colour staging, pixel capture, strobes and error count.
  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      Sync_pre      <= 4'hF;
      Sync_cur      <= 4'hF;
      vdata_o       <= {4'hF, {(3*color_width){1'b0}}};
      vdata_valid_o <= 1'b0;
      seq_err_o     <= 1'b0;
      err_cnt_o     <= '0;
      r_tmp         <= '0;
      g_tmp         <= '0;
      phase_ok      <= 1'b0;
    end else begin
      vdata_valid_o <= capture;
      seq_err_o     <= err_evt;
      err_cnt_o     <= cnt_next;
      if (is_sync) begin
        Sync_pre <= Sync_cur;
        Sync_cur <= D_i[3:0];
        phase_ok <= 1'b1;
      end else begin
        case (data_cnt)
          2'b01: r_tmp <= D_i;
          2'b10: g_tmp <= D_i;
          2'b11: begin
            if (phase_ok) begin
              vdata_o  <= {Sync_cur,
                           depth_mask(r_tmp, n15bit_mode),
                           depth_mask(g_tmp, n15bit_mode),
                           depth_mask(D_i, n15bit_mode)};
              phase_ok <= 1'b0;
            end
          end
          default: phase_ok <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_n64_vdemux.sv
// Bench for n64_vdemux: directed vector table, multi-cycle corner sequences
// (saturation, frame-start clear, reset mid-pixel) and a randomized run
// against a rule-level reference model.
module tb_n64_vdemux;

  logic        VCLK = 1'b0;
  logic        nRST;
  logic        nDSYNC;
  logic [6:0]  D_i;
  logic [3:0]  vinfo_i;
  logic        n15bit_mode;
  logic [3:0]  Sync_pre;
  logic [3:0]  Sync_cur;
  logic [24:0] vdata_o;
  logic        vdata_valid_o;
  logic        seq_err_o;
  logic [7:0]  err_cnt_o;

  int checks   = 0;
  int failures = 0;

  n64_vdemux #(.color_width(7), .err_cnt_width(8)) dut (
    .VCLK(VCLK), .nRST(nRST), .nDSYNC(nDSYNC), .D_i(D_i), .vinfo_i(vinfo_i),
    .n15bit_mode(n15bit_mode), .Sync_pre(Sync_pre), .Sync_cur(Sync_cur),
    .vdata_o(vdata_o), .vdata_valid_o(vdata_valid_o), .seq_err_o(seq_err_o),
    .err_cnt_o(err_cnt_o)
  );

  always #5 VCLK = ~VCLK;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        nds;
    logic [6:0]  d;
    logic [1:0]  dc;
    logic        n15;
    logic        ev;
    logic        ee;
    logic [7:0]  ec;
    logic [3:0]  ep;
    logic [3:0]  es;
    logic [24:0] evd;
  } vec_t;

  vec_t vq[$];

  function automatic logic [24:0] pix(input logic [3:0] s, input logic [6:0] r, g, b);
    return {s, r, g, b};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic nds, input logic [6:0] d, input logic [1:0] dc, input logic n15);
    nDSYNC      = nds;
    D_i         = d;
    vinfo_i     = {dc, 2'b00};
    n15bit_mode = n15;
  endtask

  task automatic tick();
    @(posedge VCLK);
    #1;
  endtask

  task automatic chk_all(input string p, input logic ev, ee, input logic [7:0] ec,
                         input logic [3:0] ep, es, input logic [24:0] evd);
    chk({p, "_valid"}, {31'd0, vdata_valid_o}, {31'd0, ev});
    chk({p, "_err"},   {31'd0, seq_err_o},     {31'd0, ee});
    chk({p, "_cnt"},   {24'd0, err_cnt_o},     {24'd0, ec});
    chk({p, "_pre"},   {28'd0, Sync_pre},      {28'd0, ep});
    chk({p, "_cur"},   {28'd0, Sync_cur},      {28'd0, es});
    chk({p, "_vdata"}, {7'd0, vdata_o},        {7'd0, evd});
  endtask

  task automatic add(input logic nds, input logic [6:0] d, input logic [1:0] dc, input logic n15,
                     input logic ev, ee, input logic [7:0] ec, input logic [3:0] ep, es,
                     input logic [24:0] evd);
    vec_t v;
    v.nds = nds; v.d = d; v.dc = dc; v.n15 = n15;
    v.ev = ev; v.ee = ee; v.ec = ec; v.ep = ep; v.es = es; v.evd = evd;
    vq.push_back(v);
  endtask

  // Reference model state (rules applied at the level of whole bus words).
  logic [3:0]  m_pre, m_cur;
  logic [6:0]  m_r, m_g;
  bit          m_armed;
  int          m_cnt;
  logic [24:0] m_vd;
  bit          m_valid, m_err;

  function automatic logic [6:0] m_depth(input logic [6:0] v, input logic full);
    return full ? v : 7'((int'(v) / 4) * 4);
  endfunction

  task automatic model_reset();
    m_pre = 4'hF; m_cur = 4'hF; m_r = 0; m_g = 0; m_armed = 0; m_cnt = 0;
    m_vd = pix(4'hF, 0, 0, 0); m_valid = 0; m_err = 0;
  endtask

  task automatic model_step(input logic nds, input logic [6:0] d, input logic [1:0] dc, input logic n15);
    bit frame_start;
    m_valid = 0;
    m_err   = 0;
    frame_start = 0;
    if (!nds) begin
      m_err = (dc != 0);
      frame_start = (m_cur[3] == 0) && (d[3] == 1);
      m_pre = m_cur;
      m_cur = d[3:0];
      m_armed = 1;
    end else if (dc == 1) m_r = d;
    else if (dc == 2) m_g = d;
    else if (dc == 3 && m_armed) begin
      m_vd = pix(m_cur, m_depth(m_r, n15), m_depth(m_g, n15), m_depth(d, n15));
      m_valid = 1;
      m_armed = 0;
    end else begin
      m_err = 1;
      if (dc == 0) m_armed = 0;
    end
    if (frame_start) m_cnt = m_err ? 1 : 0;
    else if (m_err && m_cnt < 255) m_cnt = m_cnt + 1;
  endtask

  initial begin
    logic [24:0] rv, v1, v2, v3, v4;
    int pos;
    rv = pix(4'hF, 7'h00, 7'h00, 7'h00);
    v1 = pix(4'hB, 7'h55, 7'h2A, 7'h7F);
    v2 = pix(4'hB, 7'h54, 7'h28, 7'h7C);
    v3 = pix(4'h7, 7'h01, 7'h02, 7'h03);
    v4 = pix(4'hF, 7'h10, 7'h20, 7'h30);

    //   nds d      dc n15 ev ee cnt pre  cur  vdata
    add(0, 7'h0B, 0, 1, 0, 0, 0, 4'hF, 4'hB, rv);
    add(1, 7'h55, 1, 1, 0, 0, 0, 4'hF, 4'hB, rv);
    add(1, 7'h2A, 2, 1, 0, 0, 0, 4'hF, 4'hB, rv);
    add(1, 7'h7F, 3, 1, 1, 0, 0, 4'hF, 4'hB, v1);
    add(0, 7'h0B, 0, 1, 0, 0, 0, 4'hB, 4'hB, v1);
    add(1, 7'h55, 1, 0, 0, 0, 0, 4'hB, 4'hB, v1);
    add(1, 7'h2A, 2, 0, 0, 0, 0, 4'hB, 4'hB, v1);
    add(1, 7'h7F, 3, 0, 1, 0, 0, 4'hB, 4'hB, v2);
    add(1, 7'h11, 3, 1, 0, 1, 1, 4'hB, 4'hB, v2);
    add(1, 7'h22, 0, 1, 0, 1, 2, 4'hB, 4'hB, v2);
    add(1, 7'h33, 3, 1, 0, 1, 3, 4'hB, 4'hB, v2);
    add(0, 7'h07, 0, 1, 0, 0, 3, 4'hB, 4'h7, v2);
    add(1, 7'h01, 1, 1, 0, 0, 3, 4'hB, 4'h7, v2);
    add(1, 7'h02, 2, 1, 0, 0, 3, 4'hB, 4'h7, v2);
    add(1, 7'h03, 3, 1, 1, 0, 3, 4'hB, 4'h7, v3);
    add(0, 7'h0F, 0, 1, 0, 0, 0, 4'h7, 4'hF, v3);
    add(0, 7'h0F, 1, 1, 0, 1, 1, 4'hF, 4'hF, v3);
    add(1, 7'h10, 1, 1, 0, 0, 1, 4'hF, 4'hF, v3);
    add(1, 7'h20, 2, 1, 0, 0, 1, 4'hF, 4'hF, v3);
    add(1, 7'h30, 3, 1, 1, 0, 1, 4'hF, 4'hF, v4);
    add(0, 7'h07, 0, 1, 0, 0, 1, 4'hF, 4'h7, v4);
    add(0, 7'h0F, 2, 1, 0, 1, 1, 4'h7, 4'hF, v4);

    // Reset state.
    nRST = 1'b0;
    drive(1, 7'h00, 1, 1);
    #12;
    chk_all("reset", 0, 0, 8'h00, 4'hF, 4'hF, rv);
    @(negedge VCLK);
    nRST = 1'b1;

    // Directed vector table.
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].nds, vq[i].d, vq[i].dc, vq[i].n15);
      tick();
      chk_all($sformatf("vec%0d", i), vq[i].ev, vq[i].ee, vq[i].ec, vq[i].ep, vq[i].es, vq[i].evd);
    end

    // Saturation: 300 errors from a count of 1 must stop at 8'hFF.
    for (int k = 1; k <= 300; k++) begin
      drive(1, 7'h00, 0, 1);
      tick();
      chk($sformatf("sat%0d", k), {24'd0, err_cnt_o}, (k + 1 < 255) ? k + 1 : 255);
    end
    drive(0, 7'h07, 0, 1);
    tick();
    chk("sat_hold", {24'd0, err_cnt_o}, 32'hFF);
    drive(0, 7'h0F, 0, 1);
    tick();
    chk("vs_clear", {24'd0, err_cnt_o}, 32'h00);
    chk("vs_pre", {28'd0, Sync_pre}, 32'h7);
    chk("vs_cur", {28'd0, Sync_cur}, 32'hF);

    // Reset asserted during the G cycle discards the partial pixel.
    drive(1, 7'h55, 1, 1);
    tick();
    drive(1, 7'h2A, 2, 1);
    @(posedge VCLK);
    #2;
    nRST = 1'b0;
    #1;
    chk_all("midrst", 0, 0, 8'h00, 4'hF, 4'hF, rv);
    drive(1, 7'h00, 1, 1);
    @(negedge VCLK);
    nRST = 1'b1;
    drive(1, 7'h7F, 3, 1);
    tick();
    chk_all("postrst_b", 0, 1, 8'h01, 4'hF, 4'hF, rv);
    drive(0, 7'h0B, 0, 1);
    tick();
    chk("postrst_sync_valid", {31'd0, vdata_valid_o}, 32'd0);
    drive(1, 7'h55, 1, 1);
    tick();
    drive(1, 7'h2A, 2, 1);
    tick();
    chk("postrst_g_valid", {31'd0, vdata_valid_o}, 32'd0);
    drive(1, 7'h7F, 3, 1);
    tick();
    chk_all("postrst_pix", 1, 0, 8'h01, 4'hF, 4'hB, v1);
    tick();
    chk("postrst_strobe_once", {31'd0, vdata_valid_o}, 32'd0);

    // Randomized run against the reference model.
    nRST = 1'b0;
    #3;
    @(negedge VCLK);
    nRST = 1'b1;
    model_reset();
    pos = 0;
    for (int c = 0; c < 2000; c++) begin
      logic nds;
      logic [1:0] dc;
      logic [6:0] d;
      logic n15;
      d   = 7'($urandom);
      n15 = 1'($urandom_range(0, 3) != 0);
      nds = (pos != 0);
      dc  = 2'(pos);
      if ($urandom_range(0, 9) == 0) begin
        nds = ($urandom_range(0, 3) != 0);
        dc  = 2'($urandom_range(0, 3));
      end
      pos = (pos + 1) % 4;
      drive(nds, d, dc, n15);
      model_step(nds, d, dc, n15);
      tick();
      chk_all($sformatf("rnd%0d", c), m_valid, m_err, 8'(m_cnt), m_pre, m_cur, m_vd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
